// File: rtl/feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : feeder_pkg                                                   |
// | Description : Shared types and helpers for the pixel_feeder ingest stage.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package feeder_pkg;

    typedef enum logic [1:0] {
        FD_IDLE        = 2'd0,
        FD_STREAM      = 2'd1,
        FD_WAIT_RESULT = 2'd2
    } feeder_state_t;

    // Digit reported when the controller never answers
    localparam logic [3:0] FD_DIGIT_TIMEOUT = 4'hF;

    // Number of pixels in one square frame
    function automatic int img_pixels(input int dim);
        return dim * dim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : feeder_fifo                                                  |
// | Description : Synchronous FIFO with registered read data. Pointers carry   |
// |               one extra wrap bit so full/empty come from an MSB compare.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module feeder_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw:0]    wr_ptr_q;
    logic [c_aw:0]    rd_ptr_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             wr_en;
    logic             rd_en;

    assign wr_en      = push_i && !full_o;
    assign rd_en      = pop_i && !empty_o;
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                        (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign pop_data_o = rd_data_q;

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= push_data_i;
        end
    end

    // Pointer advance and registered read port (read data holds between pops)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + (c_aw+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + (c_aw+1)'(1);
                rd_data_q <= mem_q[rd_ptr_q[c_aw-1:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_feeder                                                 |
// | Description : Buffers host pixels and streams exactly IMG_DIM*IMG_DIM      |
// |               pixels per frame to the CNN controller, optionally paced,    |
// |               then waits for the classified digit and counts frames.       |
// |               Define FEEDER_TIMEOUT_EN to add the result watchdog.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_feeder
    import feeder_pkg::*;
#(
    parameter int IMG_DIM        = 28,
    parameter int FIFO_DEPTH     = 32,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  pixel_o,
    output logic        pixel_o_valid,
    input  logic [3:0]  digit_i,
    input  logic        digit_i_valid,
    output logic [3:0]  result_digit,
    output logic        result_valid,
    output logic        frame_busy,
    output logic [15:0] frame_count,
    output logic        timeout_o
);
    localparam int c_frame_pix = img_pixels(IMG_DIM);
    localparam int c_pix_w     = $clog2(c_frame_pix);
    localparam int c_gap_w     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_pix_w-1:0] c_last_pix = c_pix_w'(c_frame_pix - 1);
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES);

    feeder_state_t      state_q;
    logic [c_pix_w-1:0] pix_cnt_q;
    logic [c_gap_w-1:0] gap_cnt_q;
    logic               pix_valid_q;
    logic [3:0]         result_digit_q;
    logic               result_valid_q;
    logic [15:0]        frame_count_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [c_cnt_w-1:0] fifo_count_unused;

    // Ready follows the pre-pop fill level, so a full FIFO refuses a push even while popping
    assign s_ready   = !rst && !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign fifo_pop  = (state_q == FD_STREAM) && !fifo_empty && (gap_cnt_q == '0);

    feeder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (s_pixel),
        .pop_i       (fifo_pop),
        .pop_data_o  (pixel_o),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count_unused)
    );

    assign pixel_o_valid = pix_valid_q;
    assign result_digit  = result_digit_q;
    assign result_valid  = result_valid_q;
    assign frame_count   = frame_count_q;
    assign frame_busy    = (state_q == FD_STREAM) || (state_q == FD_WAIT_RESULT);

`ifdef FEEDER_TIMEOUT_EN
    localparam logic [20:0] c_wdog_last = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] wdog_q;
    logic        timeout_q;
    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{32'(TIMEOUT_CYCLES), FD_DIGIT_TIMEOUT};
    assign timeout_o = 1'b0;
`endif

    // Frame sequencing, pixel pacing, result capture and (optionally) the watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FD_IDLE;
            pix_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            pix_valid_q    <= 1'b0;
            result_digit_q <= '0;
            result_valid_q <= 1'b0;
            frame_count_q  <= '0;
`ifdef FEEDER_TIMEOUT_EN
            wdog_q         <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            pix_valid_q    <= fifo_pop;
            result_valid_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
            if (fifo_pop) begin
                gap_cnt_q <= c_gap_load;
            end else if (gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - c_gap_w'(1);
            end

            case (state_q)
                FD_IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= FD_STREAM;
                        pix_cnt_q <= '0;
                    end
                end
                FD_STREAM: begin
                    if (fifo_pop) begin
                        if (pix_cnt_q == c_last_pix) begin
                            pix_cnt_q <= '0;
                            state_q   <= FD_WAIT_RESULT;
`ifdef FEEDER_TIMEOUT_EN
                            wdog_q    <= '0;
`endif
                        end else begin
                            pix_cnt_q <= pix_cnt_q + c_pix_w'(1);
                        end
                    end
                end
                FD_WAIT_RESULT: begin
                    // A returning digit takes priority over a same-cycle expiry
                    if (digit_i_valid) begin
                        result_digit_q <= digit_i;
                        result_valid_q <= 1'b1;
                        frame_count_q  <= frame_count_q + 16'd1;
                        state_q        <= FD_IDLE;
                    end
`ifdef FEEDER_TIMEOUT_EN
                    else if (wdog_q == c_wdog_last) begin
                        timeout_q      <= 1'b1;
                        result_digit_q <= FD_DIGIT_TIMEOUT;
                        result_valid_q <= 1'b1;
                        state_q        <= FD_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 21'd1;
                    end
`endif
                end
                default: state_q <= FD_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_feeder                                              |
// | Description : Scoreboard bench for pixel_feeder. Instance u_dut covers the |
// |               full 28x28 frame; u_dut_b (4x4, gap 3, depth 4, timeout 100) |
// |               covers pacing and the result watchdog.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pixel_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Compare one observed value with its expected value and count the result
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- instance A ----------------
    logic        rst = 1'b1;
    logic [7:0]  s_pixel = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  pixel_o;
    logic        pixel_o_valid;
    logic [3:0]  digit_i = '0;
    logic        digit_i_valid = 1'b0;
    logic [3:0]  result_digit;
    logic        result_valid;
    logic        frame_busy;
    logic [15:0] frame_count;
    logic        timeout_o;

    pixel_feeder #(
        .IMG_DIM(28), .FIFO_DEPTH(32), .GAP_CYCLES(0), .TIMEOUT_CYCLES(2000000)
    ) u_dut (
        .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .pixel_o(pixel_o), .pixel_o_valid(pixel_o_valid), .digit_i(digit_i),
        .digit_i_valid(digit_i_valid), .result_digit(result_digit), .result_valid(result_valid),
        .frame_busy(frame_busy), .frame_count(frame_count), .timeout_o(timeout_o)
    );

    // ---------------- instance B ----------------
    logic        b_rst = 1'b1;
    logic [7:0]  b_s_pixel = '0;
    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic [7:0]  b_pixel_o;
    logic        b_pixel_o_valid;
    logic [3:0]  b_digit_i = '0;
    logic        b_digit_i_valid = 1'b0;
    logic [3:0]  b_result_digit;
    logic        b_result_valid;
    logic        b_frame_busy;
    logic [15:0] b_frame_count;
    logic        b_timeout_o;

    pixel_feeder #(
        .IMG_DIM(4), .FIFO_DEPTH(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(100)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .s_pixel(b_s_pixel), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .pixel_o(b_pixel_o), .pixel_o_valid(b_pixel_o_valid), .digit_i(b_digit_i),
        .digit_i_valid(b_digit_i_valid), .result_digit(b_result_digit),
        .result_valid(b_result_valid), .frame_busy(b_frame_busy),
        .frame_count(b_frame_count), .timeout_o(b_timeout_o)
    );

    // ---------------- scoreboards ----------------
    logic [7:0] exp_q[$];
    logic [7:0] b_exp_q[$];
    logic [7:0] last_pushed = '0;
    int pulse_cnt   = 0;
    int b_pulse_cnt = 0;
    int b_last_cyc  = 0;

    // Instance A output monitor: every pulse must match the next accepted byte
    always @(negedge clk) begin
        if (pixel_o_valid === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check_val("pix_unexpected", {31'd0, pixel_o_valid}, 32'd0);
            else check_val("pix_data", {24'd0, pixel_o}, {24'd0, exp_q.pop_front()});
        end
    end

    // Instance B output monitor: data order plus pulse spacing within the frame
    always @(negedge clk) begin
        if (b_pixel_o_valid === 1'b1) begin
            if (b_pulse_cnt % 16 != 0) check_val("gap_spacing", cyc - b_last_cyc, 32'd4);
            b_last_cyc = cyc;
            b_pulse_cnt++;
            if (b_exp_q.size() == 0) check_val("b_pix_unexpected", {31'd0, b_pixel_o_valid}, 32'd0);
            else check_val("b_pix_data", {24'd0, b_pixel_o}, {24'd0, b_exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'(i * 7 + 3);
            default: return ~8'(i);
        endcase
    endfunction

    // Offer n bytes to instance A, retrying each until the handshake completes
    task automatic host_send(input int n, input int kind);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 10000) begin
            s_pixel = pat(kind, i);
            s_valid = 1'b1;
            if (s_ready === 1'b1) begin
                exp_q.push_back(s_pixel);
                last_pushed = s_pixel;
                i++;
            end
            guard++;
            tick();
        end
        s_valid = 1'b0;
        check_val("host_sent", i, n);
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        int g = 0;
        while (pulse_cnt < target && g < budget) begin
            tick();
            g++;
        end
        check_val(tag, pulse_cnt, target);
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_i       = d;
        digit_i_valid = 1'b1;
        tick();
        digit_i_valid = 1'b0;
    endtask

    initial begin
        int base;
        int acc;
        int i;
        int guard;
        int to_cnt;
        int td;
        logic       rv;
        logic [3:0] rd;
        logic [15:0] fc;

        // ---- reset ----
        tick();
        tick();
        check_val("rst_sready", {31'd0, s_ready}, 32'd0);
        check_val("rst_b_sready", {31'd0, b_s_ready}, 32'd0);
        rst   = 1'b0;
        b_rst = 1'b0;
        tick();
        check_val("rst_sready_after", {31'd0, s_ready}, 32'd1);
        check_val("rst_pixel_o", {24'd0, pixel_o}, 32'd0);
        check_val("rst_pix_valid", {31'd0, pixel_o_valid}, 32'd0);
        check_val("rst_result", {27'd0, result_valid, result_digit}, 32'd0);
        check_val("rst_busy", {31'd0, frame_busy}, 32'd0);
        check_val("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check_val("rst_timeout", {31'd0, timeout_o}, 32'd0);

        // ---- stray digit while idle is ignored ----
        send_digit(4'd5);
        check_val("stray_rv", {31'd0, result_valid}, 32'd0);
        check_val("stray_digit", {28'd0, result_digit}, 32'd0);
        check_val("stray_fc", {16'd0, frame_count}, 32'd0);

        // ---- frame 1: 784 bytes i&FF, no gap ----
        host_send(784, 0);
        wait_pulses("f1_pulses", 784, 200);
        check_val("f1_busy_wait", {31'd0, frame_busy}, 32'd1);
        check_val("f1_hold", {24'd0, pixel_o}, {24'd0, last_pushed});

        // ---- 40 bytes offered during WAIT_RESULT: FIFO absorbs 32, no pops ----
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            s_pixel = 8'(100 + acc);
            s_valid = 1'b1;
            if (s_ready === 1'b1) begin
                exp_q.push_back(s_pixel);
                acc++;
            end
            tick();
        end
        s_valid = 1'b0;
        check_val("wait_accepted", acc, 32'd32);
        check_val("wait_sready", {31'd0, s_ready}, 32'd0);
        check_val("wait_no_pop", pulse_cnt, 32'd784);
        check_val("wait_busy", {31'd0, frame_busy}, 32'd1);

        // ---- digit 7 returns ----
        send_digit(4'd7);
        check_val("d7_rv", {31'd0, result_valid}, 32'd1);
        check_val("d7_digit", {28'd0, result_digit}, 32'd7);
        check_val("d7_fc", {16'd0, frame_count}, 32'd1);
        check_val("d7_busy", {31'd0, frame_busy}, 32'd0);
        tick();
        check_val("fullpop_refuse", {31'd0, s_ready}, 32'd0);
        check_val("fullpop_no_valid_yet", {31'd0, pixel_o_valid}, 32'd0);
        check_val("rv_one_cycle", {31'd0, result_valid}, 32'd0);
        tick();
        check_val("after_pop_sready", {31'd0, s_ready}, 32'd1);

        // ---- rest of frame 2 ----
        host_send(752, 1);
        wait_pulses("f2_pulses", 2 * 784, 200);
        repeat (20) tick();
        check_val("f2_no_extra", pulse_cnt, 2 * 784);
        check_val("f2_hold", {24'd0, pixel_o}, {24'd0, last_pushed});
        send_digit(4'd3);
        check_val("d3_fc", {16'd0, frame_count}, 32'd2);

        // ---- reset after 300 pixels ----
        base = pulse_cnt;
        host_send(300, 2);
        wait_pulses("mid_pulses", base + 300, 200);
        check_val("mid_busy", {31'd0, frame_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_pixel_o", {24'd0, pixel_o}, 32'd0);
        check_val("mid_rst_outs", {26'd0, s_ready, pixel_o_valid, result_valid, frame_busy,
                                   timeout_o, 1'b0}, 32'd0);
        check_val("mid_rst_digit_fc", {12'd0, result_digit, frame_count}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        check_val("mid_rst_sready", {31'd0, s_ready}, 32'd1);
        base = pulse_cnt;
        host_send(784, 0);
        wait_pulses("f3_pulses", base + 784, 200);
        repeat (20) tick();
        check_val("f3_no_extra", pulse_cnt, base + 784);
        send_digit(4'd9);
        check_val("d9_digit_fc", {12'd0, result_digit, frame_count}, {12'd0, 4'd9, 16'd1});

        // ---- instance B: gap 3 pacing ----
        i = 0;
        guard = 0;
        while (i < 16 && guard < 500) begin
            b_s_pixel = 8'hA0 + 8'(i);
            b_s_valid = 1'b1;
            if (b_s_ready === 1'b1) begin
                b_exp_q.push_back(b_s_pixel);
                i++;
            end
            guard++;
            tick();
        end
        b_s_valid = 1'b0;
        check_val("b_host_sent", i, 32'd16);
        guard = 0;
        while (b_pulse_cnt < 16 && guard < 100) begin
            tick();
            guard++;
        end
        check_val("b_pulses", b_pulse_cnt, 32'd16);

        // ---- instance B: result watchdog ----
        to_cnt = 0;
        td = 0;
        rv = 1'b0;
        rd = '0;
        fc = '0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (b_timeout_o === 1'b1) begin
                to_cnt++;
                if (td == 0) begin
                    td = k;
                    rv = b_result_valid;
                    rd = b_result_digit;
                    fc = b_frame_count;
                end
            end
        end
        check_val("b_no_extra", b_pulse_cnt, 32'd16);
`ifdef FEEDER_TIMEOUT_EN
        check_val("to_pulses", to_cnt, 32'd1);
        check_val("to_delay", td, 32'd100);
        check_val("to_rv", {31'd0, rv}, 32'd1);
        check_val("to_digit", {28'd0, rd}, 32'hF);
        check_val("to_fc", {16'd0, fc}, 32'd0);
        check_val("to_busy", {31'd0, b_frame_busy}, 32'd0);
`else
        check_val("no_timeout", to_cnt, 32'd0);
        check_val("b_still_waiting", {31'd0, b_frame_busy}, 32'd1);
        b_digit_i       = 4'd2;
        b_digit_i_valid = 1'b1;
        tick();
        b_digit_i_valid = 1'b0;
        check_val("b_d2", {11'd0, b_result_valid, b_result_digit, b_frame_count},
                  {11'd0, 1'b1, 4'd2, 16'd1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation ran past its bound");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
